// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access sizes
// and the funct3-to-size decode used by both the lane steering and the FSM.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Undefined encodings fall through to a full-word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Variable-latency data bus: registered request side from the LSU, grant and
// read-data/ack side from the memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte enables and replication, misalignment
// detection for the incoming request, and load lane extraction with extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);
  lsu_size_e   req_size;
  lsu_size_e   ld_size;
  logic [31:0] lane;

  always_comb begin
    req_size    = f3_size(req_funct3);
    be          = 4'b1111;
    wdata_lanes = req_wdata;
    misaligned  = 1'b0;
    case (req_size)
      SZ_B: begin
        be          = 4'b0001 << req_addr_lo;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be          = 4'b0011 << req_addr_lo;
        wdata_lanes = {2{req_wdata[15:0]}};
        misaligned  = req_addr_lo[0];
      end
      default: misaligned = |req_addr_lo;
    endcase
  end

  // funct3[2] marks the unsigned variants; it is zero for W so W is unaffected.
  always_comb begin
    ld_size = f3_size(ld_funct3);
    lane    = ld_word >> {ld_addr_lo, 3'b000};
    case (ld_size)
      SZ_B:    ld_data = {{24{lane[7] & ~ld_funct3[2]}}, lane[7:0]};
      SZ_H:    ld_data = {{16{lane[15] & ~ld_funct3[2]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: stalls the core while one data-bus access is in flight,
// aborts on timeout, and returns extended load data in the DONE cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  load_store_unit_if.master bus
);
  localparam logic [15:0] TMO     = 16'(TIMEOUT_CYC);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  lsu_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              is_load_q, is_load_d;
  logic [31:0]       word_q, word_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic        access;
  logic        req_mis;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;
  logic [31:0] ld_data;

  assign access = mem_rd | mem_wr;

  lsu_align u_align (
    .req_funct3  (funct3),
    .req_addr_lo (addr[1:0]),
    .req_wdata   (wdata),
    .be          (req_be),
    .wdata_lanes (req_lanes),
    .misaligned  (req_mis),
    .ld_funct3   (funct3_q),
    .ld_addr_lo  (addr_lo_q),
    .ld_word     (word_q),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    is_load_d   = is_load_q;
    word_d      = word_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access && !req_mis) begin
          state_d     = ST_REQ;
          cnt_d       = '0;
          funct3_d    = funct3;
          addr_lo_d   = addr[1:0];
          is_load_d   = mem_rd;
          bus_req_d   = 1'b1;
          bus_we_d    = ~mem_rd;
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_be_d    = req_be;
          bus_wdata_d = req_lanes;
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
        // A completing response wins over a timeout landing in the same cycle.
        if (bus.bus_rvalid && (state_q == ST_WAIT || bus.bus_gnt)) begin
          state_d   = ST_DONE;
          word_d    = bus.bus_rdata;
          bus_req_d = 1'b0;
        end else if (cnt_d >= TMO) begin
          state_d   = ST_ERR;
          bus_req_d = 1'b0;
        end else if (state_q == ST_REQ && bus.bus_gnt) begin
          state_d   = ST_WAIT;
          bus_req_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      is_load_q   <= 1'b0;
      word_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      is_load_q   <= is_load_d;
      word_q      <= word_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign stall      = access && !req_mis && state_q != ST_DONE && state_q != ST_ERR;
  assign misaligned = (state_q == ST_IDLE) && access && req_mis;
  assign bus_err    = (state_q == ST_ERR);
  assign rdata      = (state_q == ST_DONE && is_load_q) ? ld_data : 32'd0;

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
